// File: rtl/fsmc_mux_async_master.sv
// ---------------------------------------------------------------------------
// fsmc_mux_async_master
//
// Host-side master for an asynchronous, address/data multiplexed static
// memory bus in the style of an FSMC/NOR interface. A host transaction is
// accepted in IDLE, then run through four timed phases on the bus:
//   ADDR  - low address on the AD bus, address latch (al_o) asserted
//   HOLD  - low address still driven, latch released so the device holds it
//   DATA  - write data driven with we_o low, or bus released with oe_o low
//   TURN  - chip deselected; write data held past the we_o rise
// A single 4-bit down-counter times every phase.
//
// Ports
//   clk_i     : clock, everything on its rising edge
//   rst_ni    : asynchronous active-low reset
//   stb_i     : host request (sampled in IDLE only)
//   we_i      : 1 = write, 0 = read
//   adr_i     : host address, ADDR_WIDTH bits
//   dat_i     : host write data, DATA_WIDTH bits
//   ack_o     : one-cycle completion pulse
//   dat_o     : read data, held until the next read completes
//   busy_o    : transaction in progress
//   dat_io    : multiplexed address/data bus
//   adr_hi_o  : upper address bits, valid from ADDR through TURN
//   ce_o      : chip enable, active low
//   al_o      : address latch enable, active low
//   oe_o      : output enable, active low
//   we_o      : write enable, active low
// ---------------------------------------------------------------------------
module fsmc_mux_async_master #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 16,
    parameter int ADDSET     = 2,
    parameter int ADDHLD     = 1,
    parameter int DATAST     = 3,
    parameter int BUSTURN    = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             stb_i,
    input  logic                             we_i,
    input  logic [ADDR_WIDTH-1:0]            adr_i,
    input  logic [DATA_WIDTH-1:0]            dat_i,
    output logic                             ack_o,
    output logic [DATA_WIDTH-1:0]            dat_o,
    output logic                             busy_o,
    inout  wire  [DATA_WIDTH-1:0]            dat_io,
    output logic [ADDR_WIDTH-DATA_WIDTH-1:0] adr_hi_o,
    output logic                             ce_o,
    output logic                             al_o,
    output logic                             oe_o,
    output logic                             we_o
);

    localparam int HI_WIDTH = ADDR_WIDTH - DATA_WIDTH;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [3:0] ADDSET_LD  = 4'(ADDSET - 1);
    localparam logic [3:0] ADDHLD_LD  = 4'(ADDHLD - 1);
    localparam logic [3:0] DATAST_LD  = 4'(DATAST - 1);
    localparam logic [3:0] BUSTURN_LD = 4'(BUSTURN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_DATA,
        S_TURN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;

    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic                    r_we;

    logic                    r_ce;
    logic                    r_al;
    logic                    r_oe;
    logic                    r_wen;
    logic                    r_doe;
    logic [DATA_WIDTH-1:0]   r_dout;
    logic [HI_WIDTH-1:0]     r_adr_hi;
    logic [DATA_WIDTH-1:0]   r_dat_o;
    logic                    r_ack;
    logic                    r_busy;

    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_adr_sel;
    logic                    w_ce_nxt;
    logic                    w_al_nxt;
    logic                    w_oe_nxt;
    logic                    w_wen_nxt;
    logic                    w_doe_nxt;
    logic [DATA_WIDTH-1:0]   w_dout_nxt;
    logic [HI_WIDTH-1:0]     w_adr_hi_nxt;
    logic                    w_read_capture;

    // The ack cycle is itself the single idle cycle between back-to-back
    // transactions, so a request still held during ack is taken on the edge
    // that ends it; in every busy state the host inputs are simply ignored.
    assign w_accept = (r_state == S_IDLE) && stb_i;

    // On the accept edge the address registers are loading at the same time,
    // so the ADDR-phase outputs must be taken straight from the host inputs.
    assign w_adr_sel = w_accept ? adr_i : r_adr;

    // Read data is sampled on the edge that leaves DATA, while oe_o is still low.
    assign w_read_capture = (r_state == S_DATA) && (w_state_nxt == S_TURN) && !r_we;

    // State and phase counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: each phase ends on the edge where the counter is 0,
    // at which point the counter is reloaded with the next phase's length.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = ADDSET_LD;
                end
            end
            S_ADDR: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = ADDHLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = DATAST_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_DATA: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_TURN;
                    w_cnt_nxt   = BUSTURN_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_TURN: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Bus outputs are decoded from the upcoming state and then registered,
    // so every strobe and the AD-bus enable change cleanly on the clock edge.
    always_comb begin
        w_ce_nxt     = 1'b1;
        w_al_nxt     = 1'b1;
        w_oe_nxt     = 1'b1;
        w_wen_nxt    = 1'b1;
        w_doe_nxt    = 1'b0;
        w_dout_nxt   = '0;
        w_adr_hi_nxt = '0;
        case (w_state_nxt)
            S_ADDR: begin
                w_ce_nxt     = 1'b0;
                w_al_nxt     = 1'b0;
                w_doe_nxt    = 1'b1;
                w_dout_nxt   = w_adr_sel[DATA_WIDTH-1:0];
                w_adr_hi_nxt = w_adr_sel[ADDR_WIDTH-1:DATA_WIDTH];
            end
            S_HOLD: begin
                w_ce_nxt     = 1'b0;
                w_doe_nxt    = 1'b1;
                w_dout_nxt   = r_adr[DATA_WIDTH-1:0];
                w_adr_hi_nxt = r_adr[ADDR_WIDTH-1:DATA_WIDTH];
            end
            S_DATA: begin
                w_ce_nxt     = 1'b0;
                w_adr_hi_nxt = r_adr[ADDR_WIDTH-1:DATA_WIDTH];
                if (r_we) begin
                    w_wen_nxt  = 1'b0;
                    w_doe_nxt  = 1'b1;
                    w_dout_nxt = r_dat;
                end else begin
                    w_oe_nxt = 1'b0;
                end
            end
            S_TURN: begin
                w_adr_hi_nxt = r_adr[ADDR_WIDTH-1:DATA_WIDTH];
                if (r_we) begin
                    w_doe_nxt  = 1'b1;
                    w_dout_nxt = r_dat;
                end
            end
            default: begin
                w_ce_nxt = 1'b1;
            end
        endcase
    end

    // Transaction latches, registered bus outputs, read capture and the
    // host-side handshake; reset returns the bus to its fully idle levels.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_adr    <= '0;
            r_dat    <= '0;
            r_we     <= 1'b0;
            r_ce     <= 1'b1;
            r_al     <= 1'b1;
            r_oe     <= 1'b1;
            r_wen    <= 1'b1;
            r_doe    <= 1'b0;
            r_dout   <= '0;
            r_adr_hi <= '0;
            r_dat_o  <= '0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_adr <= adr_i;
                r_dat <= dat_i;
                r_we  <= we_i;
            end
            r_ce     <= w_ce_nxt;
            r_al     <= w_al_nxt;
            r_oe     <= w_oe_nxt;
            r_wen    <= w_wen_nxt;
            r_doe    <= w_doe_nxt;
            r_dout   <= w_dout_nxt;
            r_adr_hi <= w_adr_hi_nxt;
            if (w_read_capture) begin
                r_dat_o <= dat_io;
            end
            r_ack  <= (r_state == S_TURN) && (w_state_nxt == S_IDLE);
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

    assign dat_io   = r_doe ? r_dout : 'z;
    assign ack_o    = r_ack;
    assign dat_o    = r_dat_o;
    assign busy_o   = r_busy;
    assign adr_hi_o = r_adr_hi;
    assign ce_o     = r_ce;
    assign al_o     = r_al;
    assign oe_o     = r_oe;
    assign we_o     = r_wen;

endmodule

// File: tb/tb_fsmc_mux_async_master.sv
// ---------------------------------------------------------------------------
// tb_fsmc_mux_async_master
//
// Self-checking bench for fsmc_mux_async_master. Two instances share clock
// and reset: dutA with default timing, dutB with every phase one cycle long.
// The expected bus behaviour is derived from the cycle offset since the
// accept edge: cumulative phase lengths give the phase, and a per-phase
// table gives the strobe levels. A small bus model answers reads while
// oe is low and can briefly drive probe patterns to prove the AD bus is
// released.
// ---------------------------------------------------------------------------
module tb_fsmc_mux_async_master;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int HW = AW - DW;
    localparam int AS = 2;
    localparam int AH = 1;
    localparam int DS = 3;
    localparam int BT = 1;

    localparam int PH_ADDR = 0;
    localparam int PH_HOLD = 1;
    localparam int PH_DATA = 2;
    localparam int PH_TURN = 3;
    localparam int PH_DONE = 4;

    logic clk = 1'b0;
    logic rstN;
    int   checks   = 0;
    int   failures = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    logic          stb, weIn;
    logic [AW-1:0] adr;
    logic [DW-1:0] datIn;
    logic          ack, busy, ceN, alN, oeN, weN;
    logic [DW-1:0] datOut;
    logic [HW-1:0] adrHi;
    wire  [DW-1:0] datIo;
    logic [DW-1:0] busRd;
    logic [DW-1:0] probeVal;
    logic          probeEn;

    logic          stbB, weInB;
    logic [AW-1:0] adrB;
    logic [DW-1:0] datInB;
    logic          ackB, busyB, ceNB, alNB, oeNB, weNB;
    logic [DW-1:0] datOutB;
    logic [HW-1:0] adrHiB;
    wire  [DW-1:0] datIoB;
    logic [DW-1:0] busRdB;

    // Bus device model: answers reads while oe is low; probe overrides it.
    assign datIo  = probeEn ? probeVal : (!oeN ? busRd : 'z);
    assign datIoB = !oeNB ? busRdB : 'z;

    fsmc_mux_async_master dutA (
        .clk_i(clk), .rst_ni(rstN), .stb_i(stb), .we_i(weIn), .adr_i(adr),
        .dat_i(datIn), .ack_o(ack), .dat_o(datOut), .busy_o(busy),
        .dat_io(datIo), .adr_hi_o(adrHi), .ce_o(ceN), .al_o(alN),
        .oe_o(oeN), .we_o(weN)
    );

    fsmc_mux_async_master #(
        .ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(1)
    ) dutB (
        .clk_i(clk), .rst_ni(rstN), .stb_i(stbB), .we_i(weInB), .adr_i(adrB),
        .dat_i(datInB), .ack_o(ackB), .dat_o(datOutB), .busy_o(busyB),
        .dat_io(datIoB), .adr_hi_o(adrHiB), .ce_o(ceNB), .al_o(alNB),
        .oe_o(oeNB), .we_o(weNB)
    );

    // Which phase the bus is in j cycles after the accept edge.
    function automatic int phaseAt(int j, int as, int ah, int ds, int bt);
        if (j < as)                return PH_ADDR;
        if (j < as + ah)           return PH_HOLD;
        if (j < as + ah + ds)      return PH_DATA;
        if (j < as + ah + ds + bt) return PH_TURN;
        return PH_DONE;
    endfunction

    // Expected {ce, al, oe, we, busy, ack} for a phase.
    function automatic logic [5:0] expCtl(int ph, logic isWrite);
        case (ph)
            PH_ADDR: return 6'b001110;
            PH_HOLD: return 6'b011110;
            PH_DATA: return isWrite ? 6'b011010 : 6'b010110;
            PH_TURN: return 6'b111110;
            default: return 6'b111101;
        endcase
    endfunction

    // Drives all-zeros then all-ones onto dutA's AD bus; both must read back
    // unaltered only if the DUT has released the bus.
    task automatic probeZ(output logic isZ);
        logic [DW-1:0] v0, v1;
        probeEn  = 1'b1;
        probeVal = '0;
        #1 v0 = datIo;
        probeVal = '1;
        #1 v1 = datIo;
        probeEn = 1'b0;
        isZ = (v0 === {DW{1'b0}}) && (v1 === {DW{1'b1}});
    endtask

    // Runs one dutA transaction and checks every cycle up to the ack cycle.
    task automatic doTxn(input logic isWrite, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rd,
                         input bit scramble, input bit keepStb,
                         output int ceHigh);
        int            n;
        int            ph;
        logic [5:0]    ctl;
        logic [5:0]    expC;
        logic [HW-1:0] expHi;
        logic          isZ;
        n      = AS + AH + DS + BT;
        ceHigh = 0;
        busRd  = rd;
        stb    = 1'b1;
        weIn   = isWrite;
        adr    = a;
        datIn  = d;
        @(posedge clk); #1;
        for (int j = 0; j <= n; j++) begin
            ph   = phaseAt(j, AS, AH, DS, BT);
            ctl  = {ceN, alN, oeN, weN, busy, ack};
            expC = expCtl(ph, isWrite);
            if (ceN === 1'b1) ceHigh++;
            checks++;
            if (ctl !== expC) begin
                failures++;
                $display("[TB] FAIL ctl j=%0d ph=%0d got=%b exp=%b", j, ph, ctl, expC);
            end
            expHi = (ph == PH_DONE) ? '0 : a[AW-1:DW];
            checks++;
            if (adrHi !== expHi) begin
                failures++;
                $display("[TB] FAIL adr_hi j=%0d got=%h exp=%h", j, adrHi, expHi);
            end
            if (ph == PH_ADDR || ph == PH_HOLD) begin
                checks++;
                if (datIo !== a[DW-1:0]) begin
                    failures++;
                    $display("[TB] FAIL ad_addr j=%0d got=%h exp=%h", j, datIo, a[DW-1:0]);
                end
            end else if (isWrite && (ph == PH_DATA || ph == PH_TURN)) begin
                checks++;
                if (datIo !== d) begin
                    failures++;
                    $display("[TB] FAIL ad_wdata j=%0d got=%h exp=%h", j, datIo, d);
                end
            end else if (!isWrite && (ph == PH_DATA || ph == PH_TURN)) begin
                if (ph == PH_DATA) begin
                    checks++;
                    if (datIo !== rd) begin
                        failures++;
                        $display("[TB] FAIL ad_rdata j=%0d got=%h exp=%h", j, datIo, rd);
                    end
                end
                probeZ(isZ);
                checks++;
                if (isZ !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL ad_release j=%0d got=driven exp=highZ", j);
                end
            end else if (ph == PH_DONE && !isWrite) begin
                checks++;
                if (datOut !== rd) begin
                    failures++;
                    $display("[TB] FAIL dat_o got=%h exp=%h", datOut, rd);
                end
            end
            if (j < n) begin
                if (scramble) begin
                    stb   = 1'($urandom);
                    weIn  = 1'($urandom);
                    adr   = AW'($urandom);
                    datIn = DW'($urandom);
                end else if (!keepStb) begin
                    stb = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        if (!keepStb) stb = 1'b0;
    endtask

    task automatic test_reset();
        logic isZ;
        rstN = 1'b0;
        stb = 1'b0; weIn = 1'b0; adr = '0; datIn = '0; busRd = '0;
        probeEn = 1'b0; probeVal = '0;
        stbB = 1'b0; weInB = 1'b0; adrB = '0; datInB = '0; busRdB = '0;
        #12;
        checks++;
        if ({ceN, alN, oeN, weN, busy, ack} !== 6'b111100) begin
            failures++;
            $display("[TB] FAIL reset_ctl got=%b exp=111100", {ceN, alN, oeN, weN, busy, ack});
        end
        checks++;
        if (adrHi !== '0 || datOut !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h exp=0/0", adrHi, datOut);
        end
        probeZ(isZ);
        checks++;
        if (isZ !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ad got=driven exp=highZ");
        end
        checks++;
        if ({ceNB, alNB, oeNB, weNB, busyB, ackB} !== 6'b111100 || datOutB !== '0) begin
            failures++;
            $display("[TB] FAIL reset_b got=%b/%h exp=111100/0",
                     {ceNB, alNB, oeNB, weNB, busyB, ackB}, datOutB);
        end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_vector();
        int ceh;
        doTxn(1'b1, 19'h5A5A5, 16'hBEEF, 16'h0000, 1'b0, 1'b0, ceh);
    endtask

    task automatic test_read_vector();
        int ceh;
        doTxn(1'b0, 19'h00010, 16'h0000, 16'h1234, 1'b0, 1'b0, ceh);
    endtask

    task automatic test_random();
        int ceh;
        for (int t = 0; t < 10; t++) begin
            doTxn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                  1'b0, 1'b0, ceh);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int ceh;
        doTxn(1'b1, AW'($urandom), DW'($urandom), 16'h0000, 1'b0, 1'b1, ceh);
        checks++;
        if (ceh !== BT + 1) begin
            failures++;
            $display("[TB] FAIL b2b_ce_high got=%0d exp=%0d", ceh, BT + 1);
        end
        doTxn(1'b1, AW'($urandom), DW'($urandom), 16'h0000, 1'b0, 1'b1, ceh);
        doTxn(1'b0, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0, 1'b0, ceh);
    endtask

    task automatic test_busy_ignored();
        int ceh;
        int extra;
        doTxn(1'b1, AW'($urandom), DW'($urandom), 16'h0000, 1'b1, 1'b0, ceh);
        @(posedge clk); #1;
        doTxn(1'b0, AW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b0, ceh);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ack !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("[TB] FAIL busy_extra_txn got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_mid_data();
        logic isZ;
        int   acks;
        int   ceh;
        busRd = '0;
        stb   = 1'b1;
        weIn  = 1'b1;
        adr   = AW'($urandom);
        datIn = DW'($urandom);
        @(posedge clk); #1;
        stb = 1'b0;
        repeat (AS + AH) @(posedge clk);
        #1;
        checks++;
        if (weN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_pre_data got=%b exp=0", weN);
        end
        rstN = 1'b0;
        #1;
        checks++;
        if ({ceN, alN, oeN, weN, busy, ack} !== 6'b111100 || adrHi !== '0) begin
            failures++;
            $display("[TB] FAIL rst_mid_ctl got=%b/%h exp=111100/0",
                     {ceN, alN, oeN, weN, busy, ack}, adrHi);
        end
        probeZ(isZ);
        checks++;
        if (isZ !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_ad got=driven exp=highZ");
        end
        #1 rstN = 1'b1;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ack === 1'b1 || busy === 1'b1) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_ack got=%0d exp=0", acks);
        end
        doTxn(1'b1, AW'($urandom), DW'($urandom), 16'h0000, 1'b0, 1'b0, ceh);
    endtask

    task automatic test_all_params_one();
        logic          isWrite;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        logic [5:0]    ctl, expC;
        int            ph;
        for (int t = 0; t < 4; t++) begin
            isWrite = ((t % 2) == 1);
            a       = AW'($urandom);
            d       = DW'($urandom);
            rd      = DW'($urandom);
            busRdB  = rd;
            stbB    = 1'b1;
            weInB   = isWrite;
            adrB    = a;
            datInB  = d;
            @(posedge clk); #1;
            stbB = 1'b0;
            for (int j = 0; j <= 4; j++) begin
                ph   = phaseAt(j, 1, 1, 1, 1);
                ctl  = {ceNB, alNB, oeNB, weNB, busyB, ackB};
                expC = expCtl(ph, isWrite);
                checks++;
                if (ctl !== expC) begin
                    failures++;
                    $display("[TB] FAIL ones_ctl j=%0d got=%b exp=%b", j, ctl, expC);
                end
                if (ph == PH_DATA && isWrite) begin
                    checks++;
                    if (datIoB !== d) begin
                        failures++;
                        $display("[TB] FAIL ones_wdata got=%h exp=%h", datIoB, d);
                    end
                end
                if (ph == PH_DONE && !isWrite) begin
                    checks++;
                    if (datOutB !== rd) begin
                        failures++;
                        $display("[TB] FAIL ones_dat_o got=%h exp=%h", datOutB, rd);
                    end
                end
                if (j < 4) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_write_vector();
        test_read_vector();
        test_random();
        test_back_to_back();
        test_busy_ignored();
        test_reset_mid_data();
        test_all_params_one();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
